// File: rtl/datapath_p.sv
// datapath_p -- parametrised multicycle CPU datapath with a req/ack memory FSM.
//
// Holds PC, T, Y, IR, MAR and MDR, a NREG-entry register bank, the ALU and
// the {Z,N,C,V} flag register with condition evaluation.
// A three-state memory FSM (IDLE/REQ/DONE) runs one transaction per
// mem_start and stalls the controller through busy/done.
//
// Parameters: DW (data/address width, 3*RW+4 <= DW), NREG (bank size,
// power of 2), RESET_PC (value loaded by pc_rst), TO_CYCLES (handshake
// timeout, only with DP_MEM_TIMEOUT_EN).
//
// Build option: define DP_MEM_TIMEOUT_EN to abandon a request after
// TO_CYCLES cycles without mem_ack and raise the sticky mem_err flag.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   ld_pc/ld_t/ld_y/ld_mar/ld_flag/ld_mdr_int, pc_rst, reg_wr
//                            register strobes (ignored while busy)
//   xsel, fn_sel, reg_sel    X-bus source, ALU op source, bank read index
//   mem_start/mem_we/mem_dst_ir  transaction start and its attributes
//   mem_addr/mem_wdata       MAR / MDR contents
//   mem_rdata/mem_ack        read data and completion from memory
//   mem_req/mem_we_o         request and write qualifier to memory
//   busy/done/mem_err        transaction status
//   dcond, ir_op             condition result, IR opcode field
module datapath_p #(
    parameter int unsigned   DW        = 16,
    parameter int unsigned   NREG      = 8,
    parameter logic [DW-1:0] RESET_PC  = '0,
    parameter int unsigned   TO_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ld_pc,
    input  logic                             ld_t,
    input  logic                             ld_y,
    input  logic                             ld_mar,
    input  logic                             ld_flag,
    input  logic                             pc_rst,
    input  logic [2:0]                       xsel,
    input  logic                             ld_mdr_int,
    input  logic [1:0]                       fn_sel,
    input  logic [1:0]                       reg_sel,
    input  logic                             reg_wr,
    input  logic                             mem_start,
    input  logic                             mem_we,
    input  logic                             mem_dst_ir,
    output logic [DW-1:0]                    mem_addr,
    output logic [DW-1:0]                    mem_wdata,
    input  logic [DW-1:0]                    mem_rdata,
    output logic                             mem_req,
    output logic                             mem_we_o,
    input  logic                             mem_ack,
    output logic                             busy,
    output logic                             done,
    output logic                             mem_err,
    output logic                             dcond,
    output logic [DW-3*$clog2(NREG)-1:0]     ir_op
);

    localparam int unsigned RW = $clog2(NREG);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} mstate_e;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_PASSX, OP_SHR
    } alu_op_e;

    // ---------------- registers ----------------
    logic [DW-1:0] pc_q, t_q, y_q, ir_q, mar_q, mdr_q;
    logic [DW-1:0] bank_q [NREG];
    logic [3:0]    flag_q;              // {Z, N, C, V}

    mstate_e state_q, state_d;
    logic    req_q, req_d;
    logic    we_q, we_d;
    logic    dst_ir_q, dst_ir_d;
    logic    rd_take;                   // read data accepted this cycle

`ifdef DP_MEM_TIMEOUT_EN
    localparam int unsigned CW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    // ---------------- IR fields ----------------
    logic [RW-1:0] rdst, rx, rb;
    logic [3:0]    cond;

    assign rdst  = ir_q[RW-1:0];
    assign rx    = ir_q[2*RW-1:RW];
    assign rb    = ir_q[3*RW-1:2*RW];
    assign cond  = ir_q[3*RW+3:3*RW];
    assign ir_op = ir_q[DW-1:3*RW];

    // ---------------- X bus ----------------
    logic [RW-1:0] rd_idx;
    logic [DW-1:0] x_bus;

    always_comb begin
        rd_idx = '0;
        case (reg_sel)
            2'd0:    rd_idx = rb;
            2'd1:    rd_idx = rx;
            2'd2:    rd_idx = rdst;
            default: rd_idx = '0;
        endcase
    end

    always_comb begin
        x_bus = '0;
        case (xsel)
            3'd0:    x_bus = bank_q[rd_idx];
            3'd1:    x_bus = pc_q;
            3'd2:    x_bus = t_q;
            3'd3:    x_bus = mdr_q;
            3'd4:    x_bus = DW'(1);
            default: x_bus = '0;
        endcase
    end

    // ---------------- ALU ----------------
    alu_op_e       alu_op;
    logic [DW:0]   ext;
    logic [DW-1:0] z_bus;
    logic          c_alu, v_alu;

    always_comb begin
        alu_op = OP_ADD;
        case (fn_sel)
            2'd0:    alu_op = alu_op_e'(ir_q[DW-2:DW-4]);
            2'd1:    alu_op = OP_PASSX;
            default: alu_op = OP_ADD;
        endcase
    end

    always_comb begin
        ext   = '0;
        z_bus = '0;
        c_alu = 1'b0;
        v_alu = 1'b0;
        case (alu_op)
            OP_ADD: begin
                ext   = {1'b0, y_q} + {1'b0, x_bus};
                z_bus = ext[DW-1:0];
                c_alu = ext[DW];
                v_alu = (y_q[DW-1] == x_bus[DW-1]) && (z_bus[DW-1] != y_q[DW-1]);
            end
            OP_SUB: begin
                ext   = {1'b0, y_q} - {1'b0, x_bus};
                z_bus = ext[DW-1:0];
                c_alu = ~ext[DW];       // carry means "no borrow"
                v_alu = (y_q[DW-1] != x_bus[DW-1]) && (z_bus[DW-1] != y_q[DW-1]);
            end
            OP_AND:   z_bus = y_q & x_bus;
            OP_OR:    z_bus = y_q | x_bus;
            OP_XOR:   z_bus = y_q ^ x_bus;
            OP_SHL:   z_bus = {x_bus[DW-2:0], 1'b0};
            OP_PASSX: z_bus = x_bus;
            OP_SHR:   z_bus = {1'b0, x_bus[DW-1:1]};
            default:  z_bus = '0;
        endcase
    end

    // ---------------- condition ----------------
    always_comb begin
        dcond = 1'b0;
        case (cond)
            4'd0:    dcond = 1'b1;
            4'd1:    dcond = flag_q[3];
            4'd2:    dcond = ~flag_q[3];
            4'd3:    dcond = flag_q[1];
            4'd4:    dcond = ~flag_q[1];
            4'd5:    dcond = flag_q[2];
            4'd6:    dcond = ~flag_q[2];
            4'd7:    dcond = flag_q[0];
            4'd8:    dcond = ~flag_q[0];
            default: dcond = 1'b0;
        endcase
    end

    // ---------------- memory FSM ----------------
    // REQ spans the request phase plus one cycle with mem_req already low,
    // which gives the start-to-done latency of three cycles.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        dst_ir_d = dst_ir_q;
        rd_take  = 1'b0;
`ifdef DP_MEM_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (mem_start) begin
                    state_d  = S_REQ;
                    req_d    = 1'b1;
                    we_d     = mem_we;
                    dst_ir_d = mem_dst_ir;
`ifdef DP_MEM_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            S_REQ: begin
                if (req_q) begin
                    if (mem_ack) begin
                        req_d   = 1'b0;
                        rd_take = ~we_q;
                    end
`ifdef DP_MEM_TIMEOUT_EN
                    else if (cnt_q == CW'(TO_CYCLES - 1)) begin
                        req_d = 1'b0;
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
`endif
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            dst_ir_q <= 1'b0;
`ifdef DP_MEM_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            dst_ir_q <= dst_ir_d;
`ifdef DP_MEM_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign busy      = (state_q == S_REQ);
    assign done      = (state_q == S_DONE);
    assign mem_req   = req_q;
    assign mem_we_o  = req_q & we_q;
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;

`ifdef DP_MEM_TIMEOUT_EN
    assign mem_err = err_q;
`else
    // No timeout logic in this build; TO_CYCLES is folded in only to keep it referenced.
    assign mem_err = 1'b0 & (|TO_CYCLES);
`endif

    // ---------------- datapath registers ----------------
    logic ld_ok;
    assign ld_ok = ~busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= '0;
            t_q    <= '0;
            y_q    <= '0;
            ir_q   <= '0;
            mar_q  <= '0;
            mdr_q  <= '0;
            flag_q <= '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            if (ld_ok) begin
                if (pc_rst)          pc_q <= RESET_PC;
                else if (ld_pc)      pc_q <= z_bus;
                if (ld_t)            t_q   <= z_bus;
                if (ld_y)            y_q   <= x_bus;
                if (ld_mar)          mar_q <= z_bus;
                if (ld_mdr_int)      mdr_q <= z_bus;
                if (ld_flag)         flag_q <= {(z_bus == '0), z_bus[DW-1], c_alu, v_alu};
                if (reg_wr)          bank_q[rdst] <= z_bus;
            end
            // Placed last so memory read data overrides any internal MDR load.
            if (rd_take) begin
                if (dst_ir_q) ir_q  <= mem_rdata;
                else          mdr_q <= mem_rdata;
            end
        end
    end

endmodule

// File: doc/datapath_p.md
Name: datapath_p

Overview:
Parametrised second-generation multicycle CPU datapath. Width, register count and reset PC are generic.
- Contents: PC, T, Y, IR, MAR and MDR registers; register bank; ALU; flag register with condition evaluation.
- New in this generation: a memory-interface FSM with req/ack handshake. It replaces the fixed-timing bus and stalls the controller through busy/done.
- Sits between the microprogrammed controller and the memory subsystem.

Parameters:
DW, 16, data/address width; must satisfy 3*RW+4 <= DW
NREG, 8, register-bank entries; power of 2, >= 2; RW = clog2(NREG)
RESET_PC, 0, value loaded into PC on pc_rst
TO_CYCLES, 255, handshake timeout in cycles; used only when DP_MEM_TIMEOUT_EN is defined

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
ld_pc, ld_t, ld_y, ld_mar, ld_flag  in  1 each  load strobes; each register loads from Z bus, except Y, which loads from X bus
pc_rst  in  1  synchronous: PC <= RESET_PC; has priority over ld_pc
xsel  in  3  X-bus source: 0 reg bank, 1 PC, 2 T, 3 MDR, 4 constant 1, 5-7 zero
ld_mdr_int  in  1  MDR <= Z bus
fn_sel  in  2  ALU op source: 0 IR[DW-2:DW-4], 1 PASSX, 2 ADD, 3 ADD
reg_sel  in  2  read-index source: 0 rb, 1 rx, 2 rdst, 3 zero
reg_wr  in  1  write Z bus into bank[rdst]
mem_start  in  1  start one memory transaction
mem_we  in  1  captured at mem_start: 1 write, 0 read
mem_dst_ir  in  1  captured at mem_start: read data goes to IR instead of MDR
mem_addr  out  DW  MAR contents
mem_wdata  out  DW  MDR contents
mem_rdata  in  DW  read data, valid with mem_ack
mem_req  out  1  transaction request
mem_we_o  out  1  write qualifier; valid while mem_req is high
mem_ack  in  1  memory completion
busy  out  1  transaction in flight
done  out  1  one-cycle completion pulse
mem_err  out  1  sticky timeout flag; constant 0 without the optional feature
dcond  out  1  condition result
ir_op  out  DW-3*RW  IR[DW-1:3*RW] to the controller

Behaviour:
- Reset values: rst low sets every register, bank entry, flag and FSM to 0/IDLE. mem_req, busy, done and mem_err go low immediately (asynchronous). RESET_PC is applied only by pc_rst.
- IR fields: rdst = IR[RW-1:0], rx = IR[2RW-1:RW], rb = IR[3RW-1:2RW], cond = IR[3RW+3:3RW].
- Bank read is combinational onto the X bus. Bank write occurs at the clock edge.
- ALU, with Z = f(Y, X):
  - 000 ADD Y+X; 001 SUB Y-X; 010 AND; 011 OR; 100 XOR.
  - 101 SHL1 of X; 110 PASSX; 111 SHR1 of X (logical).
  - Result is truncated to DW bits.
  - C = carry-out for ADD. For SUB, C = 1 when no borrow (Y >= X unsigned).
  - V = signed overflow for ADD/SUB.
  - C and V are 0 for all other ops.
- Flags {Z, N, C, V} update from the ALU only on ld_flag. Z = result==0; N = result MSB.
- dcond is combinational from the flags and cond:
  - 0 always 1; 1 Z; 2 !Z; 3 C; 4 !C; 5 N; 6 !N; 7 V; 8 !V; 9-15 always 0.
- Memory FSM states: IDLE, REQ, DONE.
  - IDLE: mem_start captures mem_we/mem_dst_ir and moves to REQ. mem_req and busy rise on the next cycle.
  - REQ: mem_req is held until mem_ack is sampled high. On read, mem_rdata is latched into MDR, or into IR if mem_dst_ir was captured. mem_req drops on the following cycle, then the FSM moves to DONE.
  - DONE: done is high for one cycle; busy is low; return to IDLE.
  - mem_ack in the same cycle as mem_start has no effect.
  - Minimum latency, start to done: 3 cycles for zero-wait memory.
- Stall rules:
  - mem_start during REQ or DONE is ignored.
  - While busy, all ld_*, reg_wr and pc_rst are ignored.
  - MAR and MDR are therefore stable for the whole transaction.
  - ld_mdr_int in the same cycle as a read completion: memory data wins.
- mem_ack while in IDLE or DONE is ignored.
- rst low mid-transaction aborts the transaction; no done pulse is generated.

Optional Feature:
DP_MEM_TIMEOUT_EN
- Defined: a counter starts at 0 on entry to REQ and increments each REQ cycle. When TO_CYCLES elapse without mem_ack:
  - mem_req drops and mem_err sets; mem_err is sticky until rst.
  - The FSM enters DONE, so done still pulses.
  - No register is written.
- Undefined: no counter; REQ waits indefinitely; mem_err tied to 0.

Test Plan:
- Reset, then pc_rst with RESET_PC=0x0040 -> PC=0x0040. Then xsel=1, fn_sel=1, ld_pc -> PC unchanged at 0x0040 (PASSX).
- Fetch: MAR=0x0010, mem_start with mem_dst_ir=1, mem_we=0; ack 2 cycles after req, rdata=0x1234 -> IR=0x1234, ir_op=0x1234>>9, done pulse 1 cycle, busy low during done.
- Y=0x7FFF, X=1, fn_sel=2, ld_flag -> Z=0x8000, V=1, N=1, C=0. Then cond=7 -> dcond=1.
- Y=5, X=5, SUB, ld_flag -> Z=0, Zflag=1, C=1. Then cond=2 -> dcond=0.
- Write to MAR=0x0020, MDR=0xBEEF; ld_t pulsed while busy -> mem_wdata=0xBEEF, mem_we_o=1, T unchanged. A second mem_start during REQ is ignored.
- With DP_MEM_TIMEOUT_EN and TO_CYCLES=4, never ack -> mem_req drops after 4 REQ cycles, mem_err=1, done pulses, MDR unchanged. Also: rst low mid-REQ -> mem_req low immediately, no done.
